mem_port_arbiter: RTL and testbench

- Shares one single-ported unified RAM between three requesters: instruction fetch (IF), data access (MEM stage) and the debug reader.
- Sequences each access through a fixed-latency RAM.
- Returns read data with a one-cycle ready pulse.
- Generates per-stage stall signals that feed the pipeline's hazard/stall logic.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, RAM and status signals for mem_port_arbiter.
// Each requester holds req (and its address/data) until its rdy pulses for one cycle.
// The access is complete in that cycle, and rdata is valid in that same cycle.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_u_b_h_w;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_rdy;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [2:0]  ram_u_b_h_w;
    logic [31:0] ram_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;
    logic [1:0]  fsm_state;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_u_b_h_w,
               dbg_req, dbg_addr, ram_rdata,
        output if_rdy, if_rdata, mem_rdy, mem_rdata, dbg_rdy, dbg_rdata,
               ram_addr, ram_we, ram_wdata, ram_u_b_h_w, stall_if, stall_mem, busy, fsm_state
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_u_b_h_w,
               dbg_req, dbg_addr, ram_rdata,
        input  if_rdy, if_rdata, mem_rdy, mem_rdata, dbg_rdy, dbg_rdata,
               ram_addr, ram_we, ram_wdata, ram_u_b_h_w, stall_if, stall_mem, busy, fsm_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (IF / MEM / DBG) in front of a single-ported fixed-latency RAM.
// The arbiter performs one access per LATENCY+2 cycles and has starvation protection for IF and DBG.
module mem_port_arbiter #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;
    localparam logic [1:0] ID_IF      = 2'd0;
    localparam logic [1:0] ID_MEM     = 2'd1;
    localparam logic [1:0] ID_DBG     = 2'd2;
    localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state_q, state_d, win_q, win_d, grant;
    logic [3:0]  wait_q, wait_d, if_cnt_q, if_cnt_d, dbg_cnt_q, dbg_cnt_d;
    logic [31:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
    logic [2:0]  ram_ubhw_q, ram_ubhw_d;
    logic        ram_we_q, ram_we_d, store_q, store_d, busy_q, busy_d;
    logic        if_rdy_q, if_rdy_d, mem_rdy_q, mem_rdy_d, dbg_rdy_q, dbg_rdy_d;
    logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic        any_req, if_starved, dbg_starved;

    assign any_req     = bus.if_req | bus.mem_req | bus.dbg_req;
    assign if_starved  = bus.if_req && (if_cnt_q == STARVE_LIM);
    assign dbg_starved = bus.dbg_req && (dbg_cnt_q == STARVE_LIM);

    always_comb begin
        if (if_starved)       grant = ID_IF;
        else if (dbg_starved) grant = ID_DBG;
        else if (bus.mem_req) grant = ID_MEM;
        else if (bus.if_req)  grant = ID_IF;
        else                  grant = ID_DBG;
    end

    function automatic logic [3:0] starve_next(input logic req, input logic won, input logic [3:0] cnt);
        if (won || !req) return 4'd0;
        return (cnt == STARVE_LIM) ? cnt : cnt + 4'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        wait_d      = wait_q;
        if_cnt_d    = if_cnt_q;
        dbg_cnt_d   = dbg_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_ubhw_d  = ram_ubhw_q;
        ram_we_d    = 1'b0;
        store_d     = store_q;
        if_rdy_d    = 1'b0;
        mem_rdy_d   = 1'b0;
        dbg_rdy_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d   = S_ACCESS;
                    win_d     = grant;
                    wait_d    = WAIT_INIT;
                    if_cnt_d  = starve_next(bus.if_req, grant == ID_IF, if_cnt_q);
                    dbg_cnt_d = starve_next(bus.dbg_req, grant == ID_DBG, dbg_cnt_q);
                    // IF and DBG are always word reads; only MEM carries size and direction.
                    if (grant == ID_MEM) begin
                        ram_addr_d  = bus.mem_addr;
                        ram_wdata_d = bus.mem_wdata;
                        ram_ubhw_d  = bus.mem_u_b_h_w;
                        store_d     = bus.mem_we;
                        ram_we_d    = bus.mem_we;
                    end else begin
                        ram_addr_d  = (grant == ID_IF) ? bus.if_addr : bus.dbg_addr;
                        ram_wdata_d = 32'd0;
                        ram_ubhw_d  = 3'b010;
                        store_d     = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = S_DONE;
                    case (win_q)
                        ID_IF: begin
                            if_rdy_d   = 1'b1;
                            if_rdata_d = bus.ram_rdata;
                        end
                        ID_MEM: begin
                            mem_rdy_d = 1'b1;
                            if (!store_q) mem_rdata_d = bus.ram_rdata;
                        end
                        default: begin
                            dbg_rdy_d   = 1'b1;
                            dbg_rdata_d = bus.ram_rdata;
                        end
                    endcase
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            win_q       <= ID_IF;
            wait_q      <= 4'd0;
            if_cnt_q    <= 4'd0;
            dbg_cnt_q   <= 4'd0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            ram_ubhw_q  <= 3'd0;
            ram_we_q    <= 1'b0;
            store_q     <= 1'b0;
            busy_q      <= 1'b0;
            if_rdy_q    <= 1'b0;
            mem_rdy_q   <= 1'b0;
            dbg_rdy_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            wait_q      <= wait_d;
            if_cnt_q    <= if_cnt_d;
            dbg_cnt_q   <= dbg_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_ubhw_q  <= ram_ubhw_d;
            ram_we_q    <= ram_we_d;
            store_q     <= store_d;
            busy_q      <= busy_d;
            if_rdy_q    <= if_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
            dbg_rdy_q   <= dbg_rdy_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.if_rdy      = if_rdy_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.mem_rdy     = mem_rdy_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.dbg_rdy     = dbg_rdy_q;
    assign bus.dbg_rdata   = dbg_rdata_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_u_b_h_w = ram_ubhw_q;
    assign bus.stall_if    = bus.if_req & ~if_rdy_q;
    assign bus.stall_mem   = bus.mem_req & ~mem_rdy_q;
    assign bus.busy        = busy_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LATENCY 1, 2, 3) sharing one clock.
// Each instance has a combinational RAM model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst1, rst2, rst3;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] exp_q[$];

    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b2 ();
    mem_port_arbiter_if b3 ();

    mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(4)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));
    mem_port_arbiter #(.LATENCY(2), .STARVE_MAX(4)) u_dut2 (.clk(clk), .rst(rst2), .bus(b2));
    mem_port_arbiter #(.LATENCY(3), .STARVE_MAX(4)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));

    // Address 0x10 holds 0x13; every other word is {addr[15:0], ~addr[15:0]}.
    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign b1.ram_rdata = ram_fn(b1.ram_addr);
    assign b2.ram_rdata = ram_fn(b2.ram_addr);
    assign b3.ram_rdata = ram_fn(b3.ram_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs u_dut1 with requests held and compares the order of rdy pulses with exp_q.
    task automatic collect_grants(input int n);
        int got;
        int cyc;
        logic [1:0] id;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 400) begin
            tick();
            cyc++;
            if (b1.if_rdy || b1.mem_rdy || b1.dbg_rdy) begin
                check("rdy_onehot", 32'($countones({b1.if_rdy, b1.mem_rdy, b1.dbg_rdy})), 32'd1);
                id = b1.if_rdy ? 2'd1 : (b1.mem_rdy ? 2'd2 : 2'd3);
                check($sformatf("grant_%0d", got), {30'd0, id}, {30'd0, exp_q.pop_front()});
                got++;
            end
        end
        check("grant_timeout", got, n);
    endtask

    task automatic clear_inputs();
        b1.if_req = 0; b1.mem_req = 0; b1.dbg_req = 0; b1.mem_we = 0;
        b2.if_req = 0; b2.mem_req = 0; b2.dbg_req = 0; b2.mem_we = 0;
        b3.if_req = 0; b3.mem_req = 0; b3.dbg_req = 0; b3.mem_we = 0;
        b1.if_addr = 0; b1.mem_addr = 0; b1.dbg_addr = 0; b1.mem_wdata = 0; b1.mem_u_b_h_w = 0;
        b2.if_addr = 0; b2.mem_addr = 0; b2.dbg_addr = 0; b2.mem_wdata = 0; b2.mem_u_b_h_w = 0;
        b3.if_addr = 0; b3.mem_addr = 0; b3.dbg_addr = 0; b3.mem_wdata = 0; b3.mem_u_b_h_w = 0;
    endtask

    initial begin
        clear_inputs();
        rst1 = 0; rst2 = 0; rst3 = 0;
        repeat (3) tick();
        rst1 = 1; rst2 = 1; rst3 = 1;
        tick();

        // Reset state
        check("rst_busy", b1.busy, 0);
        check("rst_ram_addr", b1.ram_addr, 0);
        check("rst_ram_we", b1.ram_we, 0);
        check("rst_rdys", {b1.if_rdy, b1.mem_rdy, b1.dbg_rdy}, 0);
        check("rst_if_rdata", b1.if_rdata, 0);
        check("rst_state", b1.fsm_state, 0);

        // IF fetch, LATENCY=1
        b1.mem_u_b_h_w = 3'b101;
        b1.if_addr = 32'h10;
        b1.if_req = 1;
        #1 check("t1_stall_c0", b1.stall_if, 1);
        tick();
        check("t1_rdy_c1", b1.if_rdy, 0);
        check("t1_stall_c1", b1.stall_if, 1);
        check("t1_busy_c1", b1.busy, 1);
        check("t1_addr_c1", b1.ram_addr, 32'h10);
        check("t1_we_c1", b1.ram_we, 0);
        check("t1_ubhw_c1", b1.ram_u_b_h_w, 3'b010);
        tick();
        check("t1_rdy_c2", b1.if_rdy, 1);
        check("t1_rdata_c2", b1.if_rdata, 32'h13);
        check("t1_stall_c2", b1.stall_if, 0);
        check("t1_busy_c2", b1.busy, 1);
        b1.if_req = 0;
        tick();
        check("t1_rdy_c3", b1.if_rdy, 0);
        check("t1_busy_c3", b1.busy, 0);
        check("t1_rdata_hold", b1.if_rdata, 32'h13);

        // MEM load, then a store that must leave mem_rdata alone
        b1.mem_req = 1; b1.mem_we = 0; b1.mem_addr = 32'h80; b1.mem_u_b_h_w = 3'b100;
        tick();
        check("ld_addr", b1.ram_addr, 32'h80);
        check("ld_ubhw", b1.ram_u_b_h_w, 3'b100);
        check("ld_we", b1.ram_we, 0);
        tick();
        check("ld_rdy", b1.mem_rdy, 1);
        check("ld_rdata", b1.mem_rdata, 32'h0080_FF7F);
        b1.mem_req = 0;
        tick();
        b1.mem_req = 1; b1.mem_we = 1; b1.mem_addr = 32'h40;
        b1.mem_wdata = 32'hDEAD_BEEF; b1.mem_u_b_h_w = 3'b010;
        #1 check("st_stall_c0", b1.stall_mem, 1);
        tick();
        check("st_we_c1", b1.ram_we, 1);
        check("st_addr_c1", b1.ram_addr, 32'h40);
        check("st_wdata_c1", b1.ram_wdata, 32'hDEAD_BEEF);
        check("st_rdy_c1", b1.mem_rdy, 0);
        tick();
        check("st_we_c2", b1.ram_we, 0);
        check("st_rdy_c2", b1.mem_rdy, 1);
        check("st_stall_c2", b1.stall_mem, 0);
        check("st_rdata_kept", b1.mem_rdata, 32'h0080_FF7F);
        b1.mem_req = 0; b1.mem_we = 0;
        tick();
        check("st_we_c3", b1.ram_we, 0);
        check("st_rdy_c3", b1.mem_rdy, 0);

        // IF vs MEM continuously: MEM x4, then starved IF, twice over
        b1.if_addr = 32'h10; b1.mem_addr = 32'h80; b1.mem_u_b_h_w = 3'b010;
        b1.if_req = 1; b1.mem_req = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(2'd2);
            exp_q.push_back(2'd1);
        end
        collect_grants(10);
        b1.if_req = 0; b1.mem_req = 0;
        tick(); tick();

        // All three requesting: DBG gets in right after the starved IF grant
        b1.dbg_addr = 32'h30;
        b1.if_req = 1; b1.mem_req = 1; b1.dbg_req = 1;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        for (int k = 0; k < 3; k++) exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        collect_grants(11);
        b1.if_req = 0; b1.mem_req = 0; b1.dbg_req = 0;
        tick(); tick();

        // LATENCY=2: IF drops its request mid-access, and pending DBG follows
        b2.if_addr = 32'h20; b2.if_req = 1;
        tick();
        check("t6_busy_c1", b2.busy, 1);
        b2.if_req = 0; b2.if_addr = 32'h99;
        b2.dbg_addr = 32'h30; b2.dbg_req = 1;
        tick();
        check("t6_addr_stable", b2.ram_addr, 32'h20);
        check("t6_rdy_c2", b2.if_rdy, 0);
        tick();
        check("t6_if_rdy_c3", b2.if_rdy, 1);
        check("t6_dbg_rdy_c3", b2.dbg_rdy, 0);
        check("t6_if_rdata", b2.if_rdata, 32'h0020_FFDF);
        tick();
        check("t6_idle_c4", b2.busy, 0);
        check("t6_if_rdy_c4", b2.if_rdy, 0);
        tick();
        check("t6_dbg_addr_c5", b2.ram_addr, 32'h30);
        check("t6_busy_c5", b2.busy, 1);
        tick();
        tick();
        check("t6_dbg_rdy_c7", b2.dbg_rdy, 1);
        check("t6_dbg_rdata", b2.dbg_rdata, 32'h0030_FFCF);
        b2.dbg_req = 0;
        tick();
        check("t6_dbg_rdy_c8", b2.dbg_rdy, 0);

        // LATENCY=3: reset during the second ACCESS cycle of a load
        b3.mem_req = 1; b3.mem_we = 0; b3.mem_addr = 32'h80; b3.mem_u_b_h_w = 3'b010;
        tick();
        tick();
        check("t5_state_c2", b3.fsm_state, 2'd1);
        #2 rst3 = 0;
        #1;
        check("t5_rst_busy", b3.busy, 0);
        check("t5_rst_addr", b3.ram_addr, 0);
        check("t5_rst_ubhw", b3.ram_u_b_h_w, 0);
        check("t5_rst_state", b3.fsm_state, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_no_rdy_in_rst", b3.mem_rdy, 0);
        end
        b3.mem_req = 0;
        rst3 = 1;
        tick();
        check("t5_idle_after", b3.busy, 0);
        b3.mem_req = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("t5_rdy_c%0d", c), b3.mem_rdy, (c == 4) ? 1'b1 : 1'b0);
        end
        check("t5_rdata", b3.mem_rdata, 32'h0080_FF7F);
        b3.mem_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
